// File: rtl/pixel_streamer.sv
// pixel_streamer: holds one WIDTH x DEPTH grayscale frame written through a simple
// write port, and on start streams it in raster order over a valid/ready handshake
// with start-of-frame, end-of-line and end-of-frame markers.
module pixel_streamer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned N  = WIDTH * DEPTH,
    localparam int unsigned AW = (N > 1) ? $clog2(N) : 1,
    localparam int unsigned XW = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    localparam int unsigned YW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          pixel_valid,
    input  logic          pixel_ready,
    output logic [7:0]    pixel,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          sof,
    output logic          eol,
    output logic          eof
);

    localparam logic [AW-1:0] IdxLast = AW'(N - 1);
    localparam logic [XW-1:0] XLast   = XW'(WIDTH - 1);

    typedef enum logic [0:0] {StIdle, StStream} state_e;

    state_e state_q, state_d;

    logic [AW-1:0] idx_q, idx_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [7:0]    pixel_q, pixel_d;
    logic          done_q, done_d;

    logic [7:0] mem_q [N];
    logic [7:0] mem_d [N];

    logic          start_acc;
    logic          xfer;
    logic          last;
    logic [AW-1:0] idx_nxt;

    assign start_acc = (state_q == StIdle) && start;
    assign xfer      = (state_q == StStream) && pixel_ready;
    assign last      = (idx_q == IdxLast);
    assign idx_nxt   = idx_q + AW'(1);

    // Frame memory next state: writes only land while idle and in range.
    always_comb begin
        mem_d = mem_q;
        if ((state_q == StIdle) && wr_en && (32'(wr_addr) < N)) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    // Frame memory storage; deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            pixel_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            x_q     <= x_d;
            y_q     <= y_d;
            pixel_q <= pixel_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: idle until start, stream until the last pixel is taken.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StStream;
                end
            end
            StStream: begin
                if (pixel_ready && last) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath next state: raster index, coordinates, pixel and done pulse.
    always_comb begin
        idx_d   = idx_q;
        x_d     = x_q;
        y_d     = y_q;
        pixel_d = pixel_q;
        done_d  = 1'b0;
        if (start_acc) begin
            idx_d   = '0;
            x_d     = '0;
            y_d     = '0;
            // mem_d so a same-cycle write to address 0 is forwarded.
            pixel_d = mem_d[0];
        end else if (xfer) begin
            if (last) begin
                done_d = 1'b1;
            end else begin
                idx_d   = idx_nxt;
                pixel_d = mem_q[idx_nxt];
                if (x_q == XLast) begin
                    x_d = '0;
                    y_d = y_q + YW'(1);
                end else begin
                    x_d = x_q + XW'(1);
                end
            end
        end
    end

    // Outputs: markers decode the registered position, gated by valid.
    always_comb begin
        busy        = (state_q == StStream);
        pixel_valid = (state_q == StStream);
        done        = done_q;
        pixel       = pixel_q;
        x           = x_q;
        y           = y_q;
        sof         = pixel_valid && (idx_q == '0);
        eol         = pixel_valid && (x_q == XLast);
        eof         = pixel_valid && last;
    end

endmodule

// File: tb/tb_pixel_streamer.sv
// Self-checking bench for pixel_streamer on a 4x3 frame using an expected-pixel
// scoreboard filled when a stream is started and drained as pixels transfer.
module tb_pixel_streamer;

    localparam int unsigned W = 4;
    localparam int unsigned D = 3;
    localparam int unsigned NPIX = W * D;

    typedef struct packed {
        logic [7:0] pixel;
        logic [1:0] x;
        logic [1:0] y;
        logic       sof;
        logic       eol;
        logic       eof;
    } beat_t;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       start;
    logic       busy;
    logic       done;
    logic       pixel_valid;
    logic       pixel_ready;
    logic [7:0] pixel;
    logic [1:0] x;
    logic [1:0] y;
    logic       sof;
    logic       eol;
    logic       eof;

    int checks;
    int failures;

    logic [7:0] model_mem [NPIX];
    beat_t      sb_q [$];

    pixel_streamer #(
        .WIDTH(W),
        .DEPTH(D)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready),
        .pixel      (pixel),
        .x          (x),
        .y          (y),
        .sof        (sof),
        .eol        (eol),
        .eof        (eof)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame();
        beat_t b;
        for (int i = 0; i < int'(NPIX); i++) begin
            b.pixel = model_mem[i];
            b.x     = 2'(i % W);
            b.y     = 2'(i / W);
            b.sof   = (i == 0);
            b.eol   = ((i % W) == W - 1);
            b.eof   = (i == int'(NPIX) - 1);
            sb_q.push_back(b);
        end
    endtask

    task automatic load_frame();
        for (int i = 0; i < int'(NPIX); i++) begin
            wr_en        = 1'b1;
            wr_addr      = 4'(i);
            wr_data      = 8'(i * 16 + 1);
            model_mem[i] = 8'(i * 16 + 1);
            tick();
        end
        wr_en = 1'b0;
    endtask

    // Starts a frame and checks every transferred pixel against the scoreboard.
    // ready_mode 0: ready held high; 1: ready = 1,0,0 repeating.
    // disturb: write addr 5 and re-pulse start mid-stream (both must be ignored).
    // fwd: write address 0 in the same cycle as start.
    // Returns in the done cycle with done_cnt = cycles from start to done.
    task automatic stream_frame(input int ready_mode, input bit disturb, input bit fwd,
                                input logic [7:0] fwd_data, output int done_cnt);
        int    cnt;
        int    first_valid;
        bit    held;
        beat_t held_beat;
        beat_t obs;
        beat_t exp;
        if (fwd) begin
            model_mem[0] = fwd_data;
            wr_en        = 1'b1;
            wr_addr      = 4'd0;
            wr_data      = fwd_data;
        end
        push_frame();
        start = 1'b1;
        tick();
        start       = 1'b0;
        wr_en       = 1'b0;
        cnt         = 1;
        done_cnt    = -1;
        first_valid = -1;
        held        = 1'b0;
        held_beat   = '0;
        while (cnt <= 200) begin
            pixel_ready = (ready_mode == 0) ? 1'b1 : (((cnt - 1) % 3) == 0);
            wr_en       = 1'b0;
            start       = 1'b0;
            if (disturb && cnt == 3) begin
                wr_en   = 1'b1;
                wr_addr = 4'd5;
                wr_data = 8'hAA;
            end
            if (disturb && cnt == 5) start = 1'b1;
            obs = {pixel, x, y, sof, eol, eof};
            if (done) begin
                done_cnt = cnt;
                checks++;
                if ({busy, pixel_valid} !== 2'b00) begin
                    failures++;
                    $display("FAIL done_cycle_idle: busy,valid=%b required 00",
                             {busy, pixel_valid});
                end
                break;
            end
            if (pixel_valid) begin
                if (first_valid < 0) first_valid = cnt;
                if (held) begin
                    checks++;
                    if (obs !== held_beat) begin
                        failures++;
                        $display("FAIL stall_stable: got %h required %h", obs, held_beat);
                    end
                end
                if (pixel_ready) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        failures++;
                        $display("FAIL extra_pixel: got %h required none", obs);
                    end else begin
                        exp = sb_q.pop_front();
                        if (obs !== exp) begin
                            failures++;
                            $display("FAIL pixel_beat: got %h required %h", obs, exp);
                        end
                    end
                end
                held      = !pixel_ready;
                held_beat = obs;
            end else begin
                held = 1'b0;
            end
            tick();
            cnt++;
        end
        wr_en = 1'b0;
        start = 1'b0;
        checks++;
        if (done_cnt < 0) begin
            failures++;
            $display("FAIL done_timeout: got no done required done within 200 cycles");
        end
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL missing_pixels: got %0d left required 0", sb_q.size());
            sb_q.delete();
        end
        checks++;
        if (first_valid != 1) begin
            failures++;
            $display("FAIL first_valid_latency: got %0d required 1", first_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if ({busy, done, pixel_valid, pixel, x, y, sof, eol, eof} !== 19'd0) begin
            failures++;
            $display("FAIL reset_state: got %h required 0",
                     {busy, done, pixel_valid, pixel, x, y, sof, eol, eof});
        end
    endtask

    task automatic test_basic();
        int dc;
        stream_frame(0, 1'b0, 1'b0, 8'h00, dc);
        checks++;
        if (dc != 13) begin
            failures++;
            $display("FAIL basic_done_time: got %0d required 13", dc);
        end
        tick();
        checks++;
        if ({done, busy} !== 2'b00) begin
            failures++;
            $display("FAIL done_single_pulse: done,busy=%b required 00", {done, busy});
        end
    endtask

    task automatic test_backpressure();
        int dc;
        stream_frame(1, 1'b0, 1'b0, 8'h00, dc);
        checks++;
        // 12 transfers with two stall cycles before each of the last 11, plus done.
        if (dc != 35) begin
            failures++;
            $display("FAIL backpressure_done_time: got %0d required 35", dc);
        end
        pixel_ready = 1'b1;
        tick();
    endtask

    task automatic test_write_during_stream();
        int dc;
        stream_frame(0, 1'b1, 1'b0, 8'h00, dc);
        // Start in the done cycle; model_mem[5] stays 81 since the write was ignored.
        stream_frame(0, 1'b0, 1'b0, 8'h00, dc);
        checks++;
        if (dc != 13) begin
            failures++;
            $display("FAIL restream_done_time: got %0d required 13", dc);
        end
        tick();
    endtask

    task automatic test_reset_abort();
        int  xfers;
        int  dc;
        bit  done_seen;
        sb_q.delete();
        push_frame();
        start       = 1'b1;
        pixel_ready = 1'b1;
        tick();
        start = 1'b0;
        xfers = 0;
        for (int i = 0; i < 50 && xfers < 6; i++) begin
            if (pixel_valid) begin
                checks++;
                if ({pixel, x, y, sof, eol, eof} !== sb_q[0]) begin
                    failures++;
                    $display("FAIL abort_pixel: got %h required %h",
                             {pixel, x, y, sof, eol, eof}, sb_q[0]);
                end
                void'(sb_q.pop_front());
                xfers++;
            end
            tick();
        end
        sb_q.delete();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({busy, done, pixel_valid, pixel, x, y, sof, eol, eof} !== 19'd0) begin
            failures++;
            $display("FAIL abort_outputs: got %h required 0",
                     {busy, done, pixel_valid, pixel, x, y, sof, eol, eof});
        end
        done_seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (done || pixel_valid) done_seen = 1'b1;
            tick();
        end
        checks++;
        if (done_seen !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_done: got activity=%b required 0", done_seen);
        end
        stream_frame(0, 1'b0, 1'b0, 8'h00, dc);
        tick();
    endtask

    task automatic test_back_to_back();
        int dc1;
        int dc2;
        stream_frame(0, 1'b0, 1'b0, 8'h00, dc1);
        stream_frame(0, 1'b0, 1'b0, 8'h00, dc2);
        checks++;
        if (dc2 != 13) begin
            failures++;
            $display("FAIL b2b_done_time: got %0d required 13", dc2);
        end
        tick();
    endtask

    task automatic test_out_of_range();
        int dc;
        wr_en   = 1'b1;
        wr_addr = 4'd12;
        wr_data = 8'hFF;
        tick();
        wr_en = 1'b0;
        stream_frame(0, 1'b0, 1'b0, 8'h00, dc);
        tick();
    endtask

    task automatic test_start_write_same_cycle();
        int dc;
        stream_frame(0, 1'b0, 1'b1, 8'h5A, dc);
        tick();
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        reset       = 1'b1;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        start       = 1'b0;
        pixel_ready = 1'b1;
        tick();
        test_reset();
        load_frame();
        test_basic();
        test_backpressure();
        test_write_during_stream();
        test_reset_abort();
        test_back_to_back();
        test_out_of_range();
        test_start_write_same_cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pixel_streamer.md
# pixel_streamer

Frame-source transmitter feeding the edge-detector pixel input. Holds one WIDTH×DEPTH 8-bit grayscale frame in an internal array, loaded through a simple write port. On `start`, it streams the frame in raster order (row 0 col 0 first), one pixel per accepted transfer, over a valid/ready handshake with start-of-frame, end-of-line and end-of-frame markers.

## Interface
- `WIDTH`, 8, pixels per row (≥1)
- `DEPTH`, 8, rows per frame (≥1)
- Derived: N = WIDTH*DEPTH; AW = max(1, $clog2(N)); XW = max(1, $clog2(WIDTH)); YW = max(1, $clog2(DEPTH))

- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `wr_en`  in  1  frame-memory write strobe
- `wr_addr`  in  AW  raster index, y*WIDTH+x
- `wr_data`  in  8  pixel value to store
- `start`  in  1  begin streaming the stored frame
- `busy`  out  1  stream in progress
- `done`  out  1  one-cycle pulse after the last pixel transfers
- `pixel_valid`  out  1  `pixel` and markers are valid
- `pixel_ready`  in  1  sink accepts the pixel
- `pixel`  out  8  current pixel value
- `x`  out  XW  column of current pixel
- `y`  out  YW  row of current pixel
- `sof`  out  1  current pixel is index 0
- `eol`  out  1  current pixel has x == WIDTH-1
- `eof`  out  1  current pixel is index N-1

## Operation
- States: IDLE and STREAM. `busy` = (state == STREAM).
- IDLE:
  - `wr_en`=1 writes mem[wr_addr]=wr_data. `wr_addr` ≥ N is ignored.
  - `start`=1 moves to STREAM, sets index=0, loads `pixel`=mem[0], x=0, y=0, sets `pixel_valid`=1 and markers for index 0.
  - If `wr_en` and `start` are both asserted in the same cycle, the write completes first. If it targets address 0, the streamed pixel is the new value.
- STREAM:
  - Transfer occurs when `pixel_valid` && `pixel_ready`.
  - With no transfer, `pixel`, `x`, `y` and the markers hold steady. `pixel_valid` never drops without a transfer.
  - On a transfer with index < N-1: index++, `pixel`=mem[index+1]. x wraps from WIDTH-1 to 0 and y increments on that wrap. Markers are recomputed for the new index.
  - On a transfer with index == N-1: `pixel_valid`=0 and state returns to IDLE. `done`=1 for exactly the next cycle.
  - `wr_en` and `start` are ignored during STREAM. The frame cannot be modified mid-stream.
- Markers are combinational functions of the registered index/x/y, gated by `pixel_valid`, so all are 0 when not valid.
- N=1: `sof`, `eol` and `eof` assert together.
- Reset: state=IDLE, index=x=y=0, and `pixel`=0, `pixel_valid`=0, `busy`=0, `done`=0, `sof`=`eol`=`eof`=0. Memory contents are not cleared.
- Reset mid-stream aborts immediately: no `done` pulse, and the next `start` restarts from index 0.
- Frame memory is an N×8 register array with asynchronous read, sized so the RTL stays in the 120–400 line range.

## Timing
- `start` sampled at edge t: `pixel_valid`=1 with mem[0] from t+1.
- With `pixel_ready` held at 1: one pixel per cycle and the last transfer at edge t+N.
  - `done`=1 and `busy`=0 during cycle t+N+1.
- A `start` asserted during the `done` cycle is accepted, giving back-to-back frames with a one-cycle gap.
- `pixel_ready` may toggle freely. Each deasserted cycle adds exactly one cycle of latency.
- Write-to-read: a write at edge t is visible to a `start` at edge t or later.

## Test plan
- Load a 4×3 frame with mem[i]=i*16+1, hold `pixel_ready`=1, pulse `start` → pixels 1,17,…,177 on 12 consecutive cycles.
  - `sof` only on the first pixel, `eol` on indices 3/7/11, `eof` only on index 11.
  - `done` pulses once, exactly 13 cycles after `start`.
- Same frame, `pixel_ready` toggling 1,0,0,1,… → every pixel appears exactly once, in order. Outputs stay stable while stalled, and total time = 12 + number of stall cycles + 1.
- `wr_en` to address 5 with data 0xAA during STREAM, then `start` again after `done` → the second stream still shows the original mem[5]=81. Extra `start` pulses during STREAM are ignored.
- Assert `reset` after the 6th transfer → next cycle all outputs are 0 and there is no `done`. A new `start` streams from pixel 1 with memory intact.
- `start` in the same cycle as `done` → second frame's first pixel is valid on the following cycle, with `sof`=1.
- `wr_addr`=12 (out of range) with data 0xFF → no array entry changes, and the stream output is unchanged.
